// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared types and defaults for the ring counter and ring checker
// Contents: ring_state_e (HUNT/CHECK/LOCKED), RING_N, RING_LOCK_CNT.
package ring_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } ring_state_e;

  localparam int RING_N        = 4;
  localparam int RING_LOCK_CNT = 4;

endpackage

// File: rtl/onehot_enc.sv
// rtl/onehot_enc.sv - combinational one-hot to binary encoder with validity flag
// Ports:
//   f   in  [N-1:0]          one-hot pattern
//   enc out [$clog2(N)-1:0]  index of the set bit (meaningful only when ok)
//   ok  out                  exactly one bit of f is set
module onehot_enc
  import ring_pkg::*;
#(
  parameter int N = RING_N
) (
  input  logic [N-1:0]         f,
  output logic [$clog2(N)-1:0] enc,
  output logic                 ok
);

  localparam int IDX_W = $clog2(N);

  // OR of the indices of all set bits; exact whenever the input is one-hot.
  always_comb begin
    enc = '0;
    for (int i = 0; i < N; i++) begin
      if (f[i]) begin
        enc = enc | IDX_W'(i);
      end
    end
  end

  assign ok = ($countones(f) == 1);

endmodule

// File: rtl/ring_checker.sv
// rtl/ring_checker.sv - verifies a one-hot ring advances one position per clock
// Ports:
//   clk       in                system clock
//   rst       in                synchronous active-high reset
//   f         in  [N-1:0]       one-hot ring pattern
//   idx       out [IDX_W-1:0]   index of the last valid sample
//   valid     out               last sample had exactly one bit set
//   locked    out               sequence currently verified
//   err_pulse out               one-cycle strobe per sequence error while locked
//   err_cnt   out [ERR_W-1:0]   saturating error count since reset
module ring_checker
  import ring_pkg::*;
#(
  parameter int N        = RING_N,
  parameter int LOCK_CNT = RING_LOCK_CNT,
  parameter int ERR_W    = 8,
  localparam int IDX_W   = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     f,
  output logic [IDX_W-1:0] idx,
  output logic             valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  // Value of the good counter on the edge whose advance completes the run.
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);

  logic [IDX_W-1:0] enc;
  logic             enc_ok;

  ring_state_e      state_q;
  logic [GW-1:0]    good_q;
  logic [IDX_W-1:0] idx_q;
  logic             valid_q;
  logic             locked_q;
  logic             err_pulse_q;
  logic [ERR_W-1:0] err_cnt_q;

  logic [IDX_W-1:0] exp_idx;
  logic [ERR_W-1:0] err_cnt_d;
  logic             advance_ok;

  onehot_enc #(.N(N)) u_enc (
    .f  (f),
    .enc(enc),
    .ok (enc_ok)
  );

  // N is a power of two, so the natural wrap of the index width gives mod N.
  assign exp_idx    = idx_q + IDX_W'(1);
  assign advance_ok = enc_ok && (enc == exp_idx);
  assign err_cnt_d  = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      good_q      <= '0;
      idx_q       <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      valid_q     <= enc_ok;
      err_pulse_q <= 1'b0;
      if (enc_ok) begin
        idx_q <= enc;
      end
      case (state_q)
        HUNT: begin
          if (enc_ok) begin
            good_q  <= '0;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (!enc_ok) begin
            good_q  <= '0;
            state_q <= HUNT;
          end else if (advance_ok) begin
            if (good_q == GOOD_LAST) begin
              good_q   <= '0;
              locked_q <= 1'b1;
              state_q  <= LOCKED;
            end else begin
              good_q <= good_q + GW'(1);
            end
          end else begin
            // Wrong but valid position: reseed from it.
            good_q <= '0;
          end
        end
        LOCKED: begin
          if (!advance_ok) begin
            err_pulse_q <= 1'b1;
            err_cnt_q   <= err_cnt_d;
            locked_q    <= 1'b0;
            good_q      <= '0;
            state_q     <= enc_ok ? CHECK : HUNT;
          end
        end
        default: begin
          good_q   <= '0;
          locked_q <= 1'b0;
          state_q  <= HUNT;
        end
      endcase
    end
  end

  assign idx       = idx_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ring_checker.sv
// tb/tb_ring_checker.sv - table-driven self-checking bench for ring_checker
module tb_ring_checker;

  typedef struct {
    logic       rst;
    logic [3:0] f;
    logic [1:0] idx;
    logic       valid;
    logic       locked;
    logic       pulse;
    logic [7:0] cnt;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [3:0] f;
  logic [1:0] idx, idx_s;
  logic       valid, locked, err_pulse;
  logic       valid_s, locked_s, err_pulse_s;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt_s;

  int checks = 0;
  int errors = 0;
  int sat_pulses = 0;
  int exp_pulses = 0;

  vec_t vecs[$];

  ring_checker #(.N(4), .LOCK_CNT(4), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .f(f), .idx(idx), .valid(valid),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  ring_checker #(.N(4), .LOCK_CNT(4), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .f(f), .idx(idx_s), .valid(valid_s),
    .locked(locked_s), .err_pulse(err_pulse_s), .err_cnt(err_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [3:0] fv, input int ix,
                     input logic v, input logic l, input logic p, input int c);
    vec_t e;
    e.rst = r; e.f = fv; e.idx = 2'(ix); e.valid = v;
    e.locked = l; e.pulse = p; e.cnt = 8'(c);
    vecs.push_back(e);
  endtask

  task automatic check(input string name, input int n, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  initial begin
    logic [3:0] oh;
    int         sat_exp;

    // reset with a non-one-hot input
    add(1, 4'b0101, 0, 0, 0, 0, 0);
    add(1, 4'b0101, 0, 0, 0, 0, 0);
    // lock acquisition: seed + 4 advances, lock on the 5th sample
    add(0, 4'b0001, 0, 1, 0, 0, 0);
    add(0, 4'b0010, 1, 1, 0, 0, 0);
    add(0, 4'b0100, 2, 1, 0, 0, 0);
    add(0, 4'b1000, 3, 1, 0, 0, 0);
    add(0, 4'b0001, 0, 1, 1, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      oh = 4'b0001 << (k % 4);
      add(0, oh, k % 4, 1, 1, 0, 0);
    end
    // invalid while locked
    add(0, 4'b0000, 0, 0, 0, 1, 1);
    add(0, 4'b0010, 1, 1, 0, 0, 1);
    add(0, 4'b0100, 2, 1, 0, 0, 1);
    add(0, 4'b1000, 3, 1, 0, 0, 1);
    add(0, 4'b0001, 0, 1, 0, 0, 1);
    add(0, 4'b0010, 1, 1, 1, 0, 1);
    add(0, 4'b0100, 2, 1, 1, 0, 1);
    add(0, 4'b1000, 3, 1, 1, 0, 1);
    add(0, 4'b0001, 0, 1, 1, 0, 1);
    add(0, 4'b0010, 1, 1, 1, 0, 1);
    // skip while locked -> CHECK seeded at 3
    add(0, 4'b1000, 3, 1, 0, 1, 2);
    add(0, 4'b0001, 0, 1, 0, 0, 2);
    add(0, 4'b0010, 1, 1, 0, 0, 2);
    add(0, 4'b0100, 2, 1, 0, 0, 2);
    add(0, 4'b1000, 3, 1, 1, 0, 2);
    add(0, 4'b0001, 0, 1, 1, 0, 2);
    add(0, 4'b0010, 1, 1, 1, 0, 2);
    add(0, 4'b0100, 2, 1, 1, 0, 2);
    // repeat while locked, then a repeat in CHECK is not an error
    add(0, 4'b0100, 2, 1, 0, 1, 3);
    add(0, 4'b0100, 2, 1, 0, 0, 3);
    add(0, 4'b1000, 3, 1, 0, 0, 3);
    add(0, 4'b0001, 0, 1, 0, 0, 3);
    add(0, 4'b0010, 1, 1, 0, 0, 3);
    add(0, 4'b0100, 2, 1, 1, 0, 3);
    // multi-bit while locked -> HUNT, idx held
    add(0, 4'b1111, 2, 0, 0, 1, 4);
    add(0, 4'b0001, 0, 1, 0, 0, 4);
    add(0, 4'b0010, 1, 1, 0, 0, 4);
    add(0, 4'b0100, 2, 1, 0, 0, 4);
    add(0, 4'b1000, 3, 1, 0, 0, 4);
    add(0, 4'b0001, 0, 1, 1, 0, 4);
    add(0, 4'b0001, 0, 1, 0, 1, 5);
    add(0, 4'b0010, 1, 1, 0, 0, 5);
    add(0, 4'b0100, 2, 1, 0, 0, 5);
    add(0, 4'b1000, 3, 1, 0, 0, 5);
    add(0, 4'b0001, 0, 1, 1, 0, 5);
    // reset mid-operation, then relock from scratch
    add(1, 4'b0010, 0, 0, 0, 0, 0);
    add(0, 4'b0010, 1, 1, 0, 0, 0);
    add(0, 4'b0100, 2, 1, 0, 0, 0);
    add(0, 4'b1000, 3, 1, 0, 0, 0);
    add(0, 4'b0001, 0, 1, 0, 0, 0);
    add(0, 4'b0010, 1, 1, 1, 0, 0);
    // invalid in HUNT and in CHECK clear progress without errors
    add(0, 4'b0011, 1, 0, 0, 1, 1);
    add(0, 4'b0000, 1, 0, 0, 0, 1);
    add(0, 4'b0100, 2, 1, 0, 0, 1);
    add(0, 4'b1000, 3, 1, 0, 0, 1);
    add(0, 4'b0000, 3, 0, 0, 0, 1);
    add(0, 4'b0001, 0, 1, 0, 0, 1);
    add(0, 4'b0010, 1, 1, 0, 0, 1);
    add(0, 4'b0100, 2, 1, 0, 0, 1);
    add(0, 4'b1000, 3, 1, 0, 0, 1);
    add(0, 4'b0001, 0, 1, 1, 0, 1);

    foreach (vecs[n]) begin
      rst = vecs[n].rst;
      f   = vecs[n].f;
      @(posedge clk);
      #1;
      if (vecs[n].pulse) exp_pulses++;
      if (err_pulse_s) sat_pulses++;
      sat_exp = (int'(vecs[n].cnt) > 3) ? 3 : int'(vecs[n].cnt);
      check("idx",       n, 32'(idx),       32'(vecs[n].idx));
      check("valid",     n, 32'(valid),     32'(vecs[n].valid));
      check("locked",    n, 32'(locked),    32'(vecs[n].locked));
      check("err_pulse", n, 32'(err_pulse), 32'(vecs[n].pulse));
      check("err_cnt",   n, 32'(err_cnt),   32'(vecs[n].cnt));
      check("sat_cnt",   n, 32'(err_cnt_s), 32'(sat_exp));
      check("sat_pulse", n, 32'(err_pulse_s), 32'(vecs[n].pulse));
    end
    check("sat_pulse_total", 0, 32'(sat_pulses), 32'(exp_pulses));
    check("pulse_total", 0, 32'(exp_pulses), 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
